// File: rtl/vga_scan_pipe_if.sv
// Bundle between the raster/pixel stage and the picture source plus VGA pins.
//   master (vga_scan_pipe): drives addresses, frame strobe and pin outputs,
//                           receives vga_data.
//   slave  (picture source / bench): drives vga_data, observes the rest.
interface vga_scan_pipe_if;
  logic [23:0] vga_data;    // {R,G,B} returned by the source
  logic [9:0]  h_addr;      // requested column, 0 outside active region
  logic [9:0]  v_addr;      // requested row, 0 outside active region
  logic        addr_valid;  // h_addr/v_addr inside active region
  logic        frame_end;   // one-clock tick on the last clock of a frame
  logic        hsync;       // active-low
  logic        vsync;       // active-low
  logic        valid;       // blank_n, aligned with vga_r/g/b
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    input  vga_data,
    output h_addr, v_addr, addr_valid, frame_end,
    output hsync, vsync, valid, vga_r, vga_g, vga_b
  );

  modport slave (
    output vga_data,
    input  h_addr, v_addr, addr_valid, frame_end,
    input  hsync, vsync, valid, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_scan_pipe.sv
// Raster timing and pixel-output stage.
// Stage 0 holds the h/v counters; addresses, addr_valid and frame_end are
// decoded combinationally from it. Sync/active flags travel through an
// RD_LAT-deep delay line so they meet the source's colour return, then all
// pin outputs are registered once more (total lag RD_LAT+1 clocks).
// Ports:
//   clk_i   pixel clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     vga_scan_pipe_if.master (source addresses/data, VGA pins)
// RD_LAT legal range is 0..3.
module vga_scan_pipe #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  vga_scan_pipe_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Flag bundle {hs_n, vs_n, active}; idle means syncs released, blanked.
  localparam logic [2:0] FLAGS_IDLE = 3'b110;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       active0;
  logic       hs0_n;
  logic       vs0_n;
  logic [2:0] flags0;
  logic [2:0] flags_dly;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        valid_q, valid_d;
  logic [23:0] rgb_q, rgb_d;

  // Stage 0 counters; v advances only on the h wrap edge.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs0_n   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs0_n   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign flags0  = {hs0_n, vs0_n, active0};

  // Addresses are zeroed in blanking so the source never sees out-of-range
  // coordinates.
  assign bus.h_addr     = active0 ? h_cnt_q : '0;
  assign bus.v_addr     = active0 ? v_cnt_q : '0;
  assign bus.addr_valid = active0;
  // Undelayed on purpose: per-frame position updates land before (0,0)
  // is requested.
  assign bus.frame_end  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  generate
    if (RD_LAT == 0) begin : g_direct
      assign flags_dly = flags0;
    end else begin : g_delay
      logic [2:0] dly_q [RD_LAT];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < RD_LAT; i++) dly_q[i] <= FLAGS_IDLE;
        end else begin
          dly_q[0] <= flags0;
          for (int i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign flags_dly = dly_q[RD_LAT-1];
    end
  endgenerate

  // Colour is gated by the delayed active flag so blanking-time garbage
  // from the source never reaches the pins.
  always_comb begin
    hsync_d = flags_dly[2];
    vsync_d = flags_dly[1];
    valid_d = flags_dly[0];
    rgb_d   = flags_dly[0] ? bus.vga_data : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      valid_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.valid = valid_q;
  assign bus.vga_r = rgb_q[23:16];
  assign bus.vga_g = rgb_q[15:8];
  assign bus.vga_b = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_pipe.sv
// Bench for vga_scan_pipe: one full-size instance (RD_LAT=1) and two
// shrunken-timing instances (RD_LAT=0 and 3) so whole frames fit in a
// short run. Sources return {x,y,A5} for active addresses and FFFFFF
// otherwise, delayed by each instance's RD_LAT.
module tb_vga_scan_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vga_scan_pipe_if ifd ();
  vga_scan_pipe_if if0 ();
  vga_scan_pipe_if if3 ();

  vga_scan_pipe #(.RD_LAT(1)) u_def (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifd.master)
  );

  vga_scan_pipe #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LAT(0)
  ) u_s0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if0.master)
  );

  vga_scan_pipe #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LAT(3)
  ) u_s3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(if3.master)
  );

  // Picture sources
  logic [23:0] srcd, src0, src3, d_pipe;
  logic [23:0] p3 [3];
  assign srcd = ifd.addr_valid ? {ifd.h_addr[7:0], ifd.v_addr[7:0], 8'hA5} : 24'hFFFFFF;
  assign src0 = if0.addr_valid ? {if0.h_addr[7:0], if0.v_addr[7:0], 8'hA5} : 24'hFFFFFF;
  assign src3 = if3.addr_valid ? {if3.h_addr[7:0], if3.v_addr[7:0], 8'hA5} : 24'hFFFFFF;
  always @(posedge clk) begin
    d_pipe <= srcd;
    p3[0]  <= src3;
    p3[1]  <= p3[0];
    p3[2]  <= p3[1];
  end
  assign ifd.vga_data = d_pipe;
  assign if0.vga_data = src0;
  assign if3.vga_data = p3[2];

  // Rising edges since reset release
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // [26]=hsync [25]=vsync [24]=valid [23:0]=rgb
  logic [26:0] pins [3];
  // [21]=frame_end [20]=addr_valid [19:10]=h_addr [9:0]=v_addr
  logic [21:0] comb [3];
  assign pins[0] = {ifd.hsync, ifd.vsync, ifd.valid, ifd.vga_r, ifd.vga_g, ifd.vga_b};
  assign pins[1] = {if0.hsync, if0.vsync, if0.valid, if0.vga_r, if0.vga_g, if0.vga_b};
  assign pins[2] = {if3.hsync, if3.vsync, if3.valid, if3.vga_r, if3.vga_g, if3.vga_b};
  assign comb[0] = {ifd.frame_end, ifd.addr_valid, ifd.h_addr, ifd.v_addr};
  assign comb[1] = {if0.frame_end, if0.addr_valid, if0.h_addr, if0.v_addr};
  assign comb[2] = {if3.frame_end, if3.addr_valid, if3.h_addr, if3.v_addr};

  int lat      [3] = '{1, 0, 3};
  bit small_tm [3] = '{1'b0, 1'b1, 1'b1};

  localparam logic [26:0] PINS_IDLE = {1'b1, 1'b1, 1'b0, 24'h0};
  localparam logic [21:0] COMB_ORG  = {1'b0, 1'b1, 10'd0, 10'd0};

  // Reference raster decode for a stage-0 position p (edges since release).
  function automatic void decode(input int p, input bit sm, output int h, output int v,
                                 output bit act, output bit hsn, output bit vsn, output bit last);
    int ha, hf, hs, hb, va, vf, vs, vb, ht, vt;
    if (sm) begin ha = 16;  hf = 4;  hs = 6;  hb = 4;  va = 8;   vf = 2;  vs = 2; vb = 3;  end
    else    begin ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; end
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = p % ht;
    v    = (p / ht) % vt;
    act  = (h < ha) && (v < va);
    hsn  = !((h >= ha + hf) && (h < ha + hf + hs));
    vsn  = !((v >= va + vf) && (v < va + vf + vs));
    last = (h == ht - 1) && (v == vt - 1);
  endfunction

  function automatic logic [26:0] exp_pins(input int p, input bit sm);
    int h, v;
    bit act, hsn, vsn, last;
    if (p < 0) return PINS_IDLE;
    decode(p, sm, h, v, act, hsn, vsn, last);
    return {hsn, vsn, act, act ? {8'(h), 8'(v), 8'hA5} : 24'h0};
  endfunction

  function automatic logic [21:0] exp_comb(input int p, input bit sm);
    int h, v;
    bit act, hsn, vsn, last;
    decode(p, sm, h, v, act, hsn, vsn, last);
    return {last, act, act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pins[i] !== PINS_IDLE) begin
        errors++;
        $display("FAIL reset_pins inst%0d got %h exp %h", i, pins[i], PINS_IDLE);
      end
      checks++;
      if (comb[i] !== COMB_ORG) begin
        errors++;
        $display("FAIL reset_comb inst%0d got %h exp %h", i, comb[i], COMB_ORG);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (comb[i] !== COMB_ORG) begin
        errors++;
        $display("FAIL release_comb inst%0d got %h exp %h", i, comb[i], COMB_ORG);
      end
    end
  endtask

  task automatic test_pixels;
    logic [26:0] ep;
    logic [21:0] ec;
    for (int n = 0; n < 8 * 800 + 10; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        ep = exp_pins(cyc - lat[i] - 1, small_tm[i]);
        ec = exp_comb(cyc, small_tm[i]);
        checks++;
        if (pins[i] !== ep) begin
          errors++;
          $display("FAIL pix_pins inst%0d cyc %0d got %h exp %h", i, cyc, pins[i], ep);
        end
        checks++;
        if (comb[i] !== ec) begin
          errors++;
          $display("FAIL pix_comb inst%0d cyc %0d got %h exp %h", i, cyc, comb[i], ec);
        end
      end
      if (cyc == 7 * 800 + 5) begin
        checks++;
        if (ifd.h_addr !== 10'd5 || ifd.v_addr !== 10'd7 || ifd.addr_valid !== 1'b1) begin
          errors++;
          $display("FAIL addr_5_7 got %0d,%0d,%b exp 5,7,1", ifd.h_addr, ifd.v_addr, ifd.addr_valid);
        end
      end
      if (cyc == 7 * 800 + 5 + 2) begin
        checks++;
        if (ifd.vga_r !== 8'd5 || ifd.vga_g !== 8'd7 || ifd.vga_b !== 8'hA5 || ifd.valid !== 1'b1) begin
          errors++;
          $display("FAIL pixel_5_7 got r%h g%h b%h v%b exp r05 g07 bA5 v1",
                   ifd.vga_r, ifd.vga_g, ifd.vga_b, ifd.valid);
        end
      end
    end
  endtask

  task automatic test_line_timing;
    int vr_prev, vf_cyc, hf_cyc, nrise;
    bit have_vr, have_vf, have_hf, pv, ph;
    have_vr = 0; have_vf = 0; have_hf = 0; nrise = 0;
    pv = ifd.valid; ph = ifd.hsync;
    vr_prev = 0; vf_cyc = 0; hf_cyc = 0;
    repeat (2000) begin
      tick();
      if (ifd.valid && !pv) begin
        nrise++;
        if (have_vr) begin
          checks++;
          if (cyc - vr_prev != 800) begin
            errors++;
            $display("FAIL line_period got %0d exp 800", cyc - vr_prev);
          end
        end
        vr_prev = cyc; have_vr = 1;
      end
      if (!ifd.valid && pv) begin
        if (have_vr) begin
          checks++;
          if (cyc - vr_prev != 640) begin
            errors++;
            $display("FAIL valid_width got %0d exp 640", cyc - vr_prev);
          end
        end
        vf_cyc = cyc; have_vf = 1;
      end
      if (!ifd.hsync && ph) begin
        if (have_vf) begin
          checks++;
          if (cyc - vf_cyc != 16) begin
            errors++;
            $display("FAIL hsync_offset got %0d exp 16", cyc - vf_cyc);
          end
        end
        hf_cyc = cyc; have_hf = 1;
      end
      if (ifd.hsync && !ph && have_hf) begin
        checks++;
        if (cyc - hf_cyc != 96) begin
          errors++;
          $display("FAIL hsync_width got %0d exp 96", cyc - hf_cyc);
        end
      end
      pv = ifd.valid; ph = ifd.hsync;
    end
    checks++;
    if (nrise < 2) begin
      errors++;
      $display("FAIL line_events got %0d valid rises exp >=2", nrise);
    end
  endtask

  task automatic test_frame_timing;
    int fe_prev, fe_n, vs_fall;
    bit have_fe, have_vs, pvs, after_fe;
    fe_prev = 0; fe_n = 0; vs_fall = 0;
    have_fe = 0; have_vs = 0; after_fe = 0; pvs = if0.vsync;
    repeat (1350) begin
      tick();
      if (after_fe) begin
        checks++;
        if (comb[1] !== COMB_ORG) begin
          errors++;
          $display("FAIL fe_next got %h exp %h", comb[1], COMB_ORG);
        end
        after_fe = 0;
      end
      if (if0.frame_end) begin
        fe_n++;
        if (have_fe) begin
          checks++;
          if (cyc - fe_prev != 450) begin
            errors++;
            $display("FAIL fe_period got %0d exp 450", cyc - fe_prev);
          end
        end
        fe_prev = cyc; have_fe = 1; after_fe = 1;
      end
      if (!if0.vsync && pvs) begin
        if (have_fe) begin
          checks++;
          if (cyc - fe_prev != 302) begin
            errors++;
            $display("FAIL vs_start got %0d exp 302", cyc - fe_prev);
          end
        end
        vs_fall = cyc; have_vs = 1;
      end
      if (if0.vsync && !pvs && have_vs) begin
        checks++;
        if (cyc - vs_fall != 60) begin
          errors++;
          $display("FAIL vs_width got %0d exp 60", cyc - vs_fall);
        end
      end
      pvs = if0.vsync;
    end
    checks++;
    if (fe_n != 3) begin
      errors++;
      $display("FAIL fe_count got %0d exp 3", fe_n);
    end
  endtask

  task automatic test_blanking;
    repeat (1000) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (!pins[i][24]) begin
          checks++;
          if (pins[i][23:0] !== 24'h0) begin
            errors++;
            $display("FAIL blank_rgb inst%0d got %h exp 000000", i, pins[i][23:0]);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset;
    logic [26:0] ep;
    logic [21:0] ec;
    for (int n = 0; n < 450 && (cyc % 450) != 128; n++) tick();
    checks++;
    if (comb[1] !== {1'b0, 1'b1, 10'd8, 10'd4}) begin
      errors++;
      $display("FAIL mid_pos got %h exp %h", comb[1], {1'b0, 1'b1, 10'd8, 10'd4});
    end
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pins[i] !== PINS_IDLE) begin
        errors++;
        $display("FAIL async_pins inst%0d got %h exp %h", i, pins[i], PINS_IDLE);
      end
      checks++;
      if (comb[i] !== COMB_ORG) begin
        errors++;
        $display("FAIL async_comb inst%0d got %h exp %h", i, comb[i], COMB_ORG);
      end
    end
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 900; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        ep = exp_pins(cyc - lat[i] - 1, small_tm[i]);
        ec = exp_comb(cyc, small_tm[i]);
        checks++;
        if (pins[i] !== ep) begin
          errors++;
          $display("FAIL restart_pins inst%0d cyc %0d got %h exp %h", i, cyc, pins[i], ep);
        end
        checks++;
        if (comb[i] !== ec) begin
          errors++;
          $display("FAIL restart_comb inst%0d cyc %0d got %h exp %h", i, cyc, comb[i], ec);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (pins[2] !== {1'b1, 1'b1, 1'b1, 24'h0000A5}) begin
          errors++;
          $display("FAIL first_pix_lat3 got %h exp %h", pins[2], {1'b1, 1'b1, 1'b1, 24'h0000A5});
        end
      end
      if (cyc == 1) begin
        checks++;
        if (pins[1] !== {1'b1, 1'b1, 1'b1, 24'h0000A5}) begin
          errors++;
          $display("FAIL first_pix_lat0 got %h exp %h", pins[1], {1'b1, 1'b1, 1'b1, 24'h0000A5});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_line_timing();
    test_frame_timing();
    test_blanking();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
